// File: rtl/bus_terminal_port.sv
// bus_terminal_port: device-side bus endpoint with a FWFT TX FIFO toward the bus and a FWFT RX FIFO toward the device
// Ports: clk/reset (async, active-high); dev_wr/dev_wr_data/dev_full load TX; pndng/D_pop/pop are the bus TX handshake;
// push/D_push deliver RX; dev_rd/dev_rd_data/dev_rx_vld drain RX; tx_count/rx_count occupancy;
// tx_drop_cnt/rx_ovf_cnt saturating drop counters; proto_err sticky protocol error.
// Optional: define BUS_TERMINAL_ADDR_CHECK_EN to store only pushes addressed to id or broadcast.
module bus_terminal_port #(
    parameter int          pckg_sz    = 16,
    parameter int          fifo_depth = 8,
    parameter logic [7:0]  id         = 8'd0,
    parameter logic [7:0]  broadcast  = 8'hFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          dev_wr,
    input  logic [pckg_sz-1:0]            dev_wr_data,
    output logic                          dev_full,
    output logic                          pndng,
    output logic [pckg_sz-1:0]            D_pop,
    input  logic                          pop,
    input  logic                          push,
    input  logic [pckg_sz-1:0]            D_push,
    input  logic                          dev_rd,
    output logic [pckg_sz-1:0]            dev_rd_data,
    output logic                          dev_rx_vld,
    output logic [$clog2(fifo_depth):0]   tx_count,
    output logic [$clog2(fifo_depth):0]   rx_count,
    output logic [7:0]                    tx_drop_cnt,
    output logic [7:0]                    rx_ovf_cnt,
    output logic                          proto_err
);
    localparam int aw = $clog2(fifo_depth);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] depth_c = cw'(fifo_depth);
`ifdef BUS_TERMINAL_ADDR_CHECK_EN
    localparam bit addr_chk = 1'b1;
`else
    localparam bit addr_chk = 1'b0;
`endif

    logic [pckg_sz-1:0] tx_mem [fifo_depth];
    logic [pckg_sz-1:0] rx_mem [fifo_depth];
    logic [aw-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;
    logic               tx_empty, tx_full, rx_empty, rx_full;
    logic               tx_wr, tx_rd, rx_wr, rx_rd, addr_ok;

    assign tx_empty    = tx_count == '0;
    assign tx_full     = tx_count == depth_c;
    assign rx_empty    = rx_count == '0;
    assign rx_full     = rx_count == depth_c;
    // A retiring read frees its slot on the same edge, so a full FIFO still accepts a write alongside it.
    assign tx_rd       = pop && !tx_empty;
    assign tx_wr       = dev_wr && (!tx_full || tx_rd);
    assign rx_rd       = dev_rd && !rx_empty;
    assign addr_ok     = !addr_chk || D_push[pckg_sz-1 -: 8] == id || D_push[pckg_sz-1 -: 8] == broadcast;
    assign rx_wr       = push && addr_ok && (!rx_full || rx_rd);
    assign dev_full    = tx_full;
    assign pndng       = !tx_empty;
    assign dev_rx_vld  = !rx_empty;
    assign D_pop       = tx_empty ? '0 : tx_mem[tx_rp];
    assign dev_rd_data = rx_empty ? '0 : rx_mem[rx_rp];

    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[tx_wp] <= dev_wr_data;
        if (rx_wr) rx_mem[rx_wp] <= D_push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wp       <= '0;
            tx_rp       <= '0;
            rx_wp       <= '0;
            rx_rp       <= '0;
            tx_count    <= '0;
            rx_count    <= '0;
            tx_drop_cnt <= '0;
            rx_ovf_cnt  <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (tx_wr) tx_wp <= tx_wp + aw'(1);
            if (tx_rd) tx_rp <= tx_rp + aw'(1);
            if (rx_wr) rx_wp <= rx_wp + aw'(1);
            if (rx_rd) rx_rp <= rx_rp + aw'(1);
            tx_count <= tx_count + cw'(tx_wr) - cw'(tx_rd);
            rx_count <= rx_count + cw'(rx_wr) - cw'(rx_rd);
            if (dev_wr && !tx_wr && tx_drop_cnt != 8'hFF) tx_drop_cnt <= tx_drop_cnt + 8'd1;
            if (push && !rx_wr && rx_ovf_cnt != 8'hFF) rx_ovf_cnt <= rx_ovf_cnt + 8'd1;
            if ((pop && tx_empty) || (push && !addr_ok)) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_terminal_port.sv
// tb_bus_terminal_port: directed self-checking bench for bus_terminal_port
module tb_bus_terminal_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dev_wr = 1'b0, pop = 1'b0, push = 1'b0, dev_rd = 1'b0;
    logic [15:0] dev_wr_data = '0, D_push = '0;
    logic        dev_full, pndng, dev_rx_vld, proto_err;
    logic [15:0] D_pop, dev_rd_data;
    logic [3:0]  tx_count, rx_count;
    logic [7:0]  tx_drop_cnt, rx_ovf_cnt;
    int          checks = 0;
    int          fails = 0;

    bus_terminal_port #(.pckg_sz(16), .fifo_depth(8), .id(8'd3), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .dev_wr(dev_wr), .dev_wr_data(dev_wr_data), .dev_full(dev_full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push), .dev_rd(dev_rd),
        .dev_rd_data(dev_rd_data), .dev_rx_vld(dev_rx_vld), .tx_count(tx_count), .rx_count(rx_count),
        .tx_drop_cnt(tx_drop_cnt), .rx_ovf_cnt(rx_ovf_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        chk("rst_pndng", pndng, 0);
        chk("rst_full", dev_full, 0);
        chk("rst_rxvld", dev_rx_vld, 0);
        chk("rst_dpop", D_pop, 0);
        chk("rst_rddata", dev_rd_data, 0);
        chk("rst_txcnt", tx_count, 0);
        chk("rst_rxcnt", rx_count, 0);
        chk("rst_drop", tx_drop_cnt, 0);
        chk("rst_ovf", rx_ovf_cnt, 0);
        chk("rst_perr", proto_err, 0);

        dev_wr = 1'b1; dev_wr_data = 16'h02A1;
        cycle();
        chk("tx1_pndng", pndng, 1);
        chk("tx1_dpop", D_pop, 16'h02A1);
        dev_wr_data = 16'h02A2;
        cycle();
        dev_wr = 1'b0;
        chk("tx2_cnt", tx_count, 2);
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        chk("tx_pop1_dpop", D_pop, 16'h02A2);
        chk("tx_pop1_cnt", tx_count, 1);
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        chk("tx_pop2_pndng", pndng, 0);
        chk("tx_pop2_cnt", tx_count, 0);
        chk("tx_pop2_dpop", D_pop, 0);

        for (int i = 0; i < 9; i++) begin
            dev_wr = 1'b1; dev_wr_data = 16'h0101 + 16'(i);
            cycle();
            if (i == 6) chk("full_before8", dev_full, 0);
            if (i == 7) chk("full_after8", dev_full, 1);
        end
        dev_wr = 1'b0;
        chk("full_cnt", tx_count, 8);
        chk("full_drop", tx_drop_cnt, 1);
        dev_wr = 1'b1; dev_wr_data = 16'hBEEF; pop = 1'b1;
        cycle();
        dev_wr = 1'b0; pop = 1'b0;
        chk("wrpop_full_cnt", tx_count, 8);
        chk("wrpop_full_drop", tx_drop_cnt, 1);
        for (int i = 0; i < 8; i++) begin
            chk("full_drain", D_pop, i < 7 ? 32'h0102 + 32'(i) : 32'hBEEF);
            pop = 1'b1;
            cycle();
            pop = 1'b0;
        end
        chk("full_drain_pndng", pndng, 0);
        chk("full_perr", proto_err, 0);

        for (int i = 0; i < 10; i++) begin
            push = 1'b1; D_push = 16'h0301 + 16'(i);
            cycle();
        end
        push = 1'b0;
        chk("rx_cnt", rx_count, 8);
        chk("rx_ovf", rx_ovf_cnt, 2);
        chk("rx_vld", dev_rx_vld, 1);
        push = 1'b1; D_push = 16'h03AA; dev_rd = 1'b1;
        cycle();
        push = 1'b0; dev_rd = 1'b0;
        chk("rx_pushrd_cnt", rx_count, 8);
        chk("rx_pushrd_ovf", rx_ovf_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            chk("rx_drain", dev_rd_data, i < 7 ? 32'h0302 + 32'(i) : 32'h03AA);
            dev_rd = 1'b1;
            cycle();
            dev_rd = 1'b0;
        end
        chk("rx_empty_vld", dev_rx_vld, 0);
        chk("rx_empty_data", dev_rd_data, 0);
        dev_rd = 1'b1;
        cycle();
        dev_rd = 1'b0;
        chk("rx_rd_empty_cnt", rx_count, 0);
        chk("rx_rd_empty_perr", proto_err, 0);

        pop = 1'b1;
        cycle();
        pop = 1'b0;
        chk("perr_set", proto_err, 1);
        chk("perr_txcnt", tx_count, 0);
        cycle();
        cycle();
        chk("perr_sticky", proto_err, 1);

        for (int i = 0; i < 20; i++) begin
            if (i >= 2) chk("wrap_head", D_pop, 32'h0200 + 32'(i - 2));
            dev_wr = 1'b1; dev_wr_data = 16'h0200 + 16'(i); pop = (i >= 2);
            cycle();
        end
        pop = 1'b0; dev_wr_data = 16'h0214;
        cycle();
        dev_wr = 1'b0;
        chk("wrap_cnt", tx_count, 3);
        chk("wrap_head_end", D_pop, 16'h0212);
        #3 reset = 1'b1;
        #1;
        chk("midrst_pndng", pndng, 0);
        chk("midrst_cnt", tx_count, 0);
        chk("midrst_dpop", D_pop, 0);
        chk("midrst_perr", proto_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        cycle();
        chk("postrst_pndng", pndng, 0);

        push = 1'b1; D_push = 16'h03FF;
        cycle();
        D_push = 16'hFF00;
        cycle();
        D_push = 16'h0500;
        cycle();
        push = 1'b0;
`ifdef BUS_TERMINAL_ADDR_CHECK_EN
        chk("addr_cnt", rx_count, 2);
        chk("addr_ovf", rx_ovf_cnt, 1);
        chk("addr_perr", proto_err, 1);
`else
        chk("addr_cnt", rx_count, 3);
        chk("addr_ovf", rx_ovf_cnt, 0);
        chk("addr_perr", proto_err, 0);
`endif
        chk("addr_head0", dev_rd_data, 16'h03FF);
        dev_rd = 1'b1;
        cycle();
        chk("addr_head1", dev_rd_data, 16'hFF00);
        cycle();
        dev_rd = 1'b0;
`ifdef BUS_TERMINAL_ADDR_CHECK_EN
        chk("addr_head2", dev_rx_vld, 0);
`else
        chk("addr_head2", dev_rd_data, 16'h0500);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
